// File: rtl/apb_spi_master_pkg.sv
// Shared constants for the APB SPI master: register word offsets, STATUS bits, FSM states.
package apb_spi_master_pkg;

   localparam int unsigned CNT_W     = 6;
   localparam int unsigned FRAME_MAX = 32;

   // Register word index, taken from paddr[4:2]
   localparam logic [2:0] REG_DATA   = 3'd0;
   localparam logic [2:0] REG_CNT    = 3'd1;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam logic [2:0] REG_DIV    = 3'd3;
   localparam logic [2:0] REG_CS     = 3'd4;

   localparam int unsigned STATUS_BUSY = 0;
   localparam int unsigned STATUS_DONE = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } spi_state_t;

endpackage

// File: rtl/apb_spi_master_spi_shift_core.sv
// Mode-0 MSB-first shift engine: half-period divider, TX bit select, RX shift, SCK/MOSI pads.
module spi_shift_core
   import apb_spi_master_pkg::*;
#(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] frame_len,
   input  logic [31:0]      tx,
   input  logic [DIV_W-1:0] div,
   input  logic             clr_done,
   input  logic             miso,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining,
   output logic [31:0]      rx,
   output logic             sck,
   output logic             mosi
);

   spi_state_t       state;
   spi_state_t       state_nxt;
   logic [DIV_W-1:0] tc;
   logic [31:0]      rxsh;
   logic             miso_meta;
   logic             miso_sync;
   logic             tc_zero;
   logic             last_bit;
   logic [CNT_W-1:0] rem_dec;
   logic             load_frame;
   logic             lo_end;
   logic             hi_end;

   assign tc_zero  = (tc == '0);
   assign rem_dec  = remaining - CNT_W'(1);
   assign last_bit = (rem_dec == '0);
   assign busy     = (state != ST_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: IDLE -> LO on start, LO <-> HI on divider expiry, HI -> IDLE after last bit
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)   state_nxt = ST_LO;
         ST_LO:   if (tc_zero) state_nxt = ST_HI;
         ST_HI:   if (tc_zero) state_nxt = last_bit ? ST_IDLE : ST_LO;
         default:              state_nxt = ST_IDLE;
      endcase
   end

   // Per-state datapath strobes
   always_comb begin
      load_frame = 1'b0;
      lo_end     = 1'b0;
      hi_end     = 1'b0;
      case (state)
         ST_IDLE: load_frame = start;
         ST_LO:   lo_end     = tc_zero;
         ST_HI:   hi_end     = tc_zero;
         default: ;
      endcase
   end

   // Two-flop MISO synchroniser
   always_ff @(posedge clk) begin
      if (reset) begin
         miso_meta <= 1'b0;
         miso_sync <= 1'b0;
      end else begin
         miso_meta <= miso;
         miso_sync <= miso_meta;
      end
   end

   // Divider, shift registers, pads and done flag (set has priority over clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         tc        <= '0;
         rxsh      <= '0;
         rx        <= '0;
         remaining <= '0;
         done      <= 1'b0;
         sck       <= 1'b0;
         mosi      <= 1'b1;
      end else begin
         if (clr_done) done <= 1'b0;
         if (load_frame) begin
            remaining <= frame_len;
            rxsh      <= '0;
            mosi      <= tx[5'(frame_len - CNT_W'(1))];
            sck       <= 1'b0;
            tc        <= div;
         end else if (lo_end) begin
            rxsh <= {rxsh[30:0], miso_sync};
            sck  <= 1'b1;
            tc   <= div;
         end else if (hi_end) begin
            sck       <= 1'b0;
            remaining <= rem_dec;
            if (last_bit) begin
               rx   <= rxsh;
               done <= 1'b1;
               mosi <= 1'b1;
            end else begin
               mosi <= tx[5'(rem_dec - CNT_W'(1))];
               tc   <= div;
            end
         end else if (state != ST_IDLE) begin
            tc <= tc - DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/apb_spi_master.sv
// APB3 front end for the SPI shift engine: register decode, register file, write stall while busy.
module apb_spi_master
   import apb_spi_master_pkg::*;
#(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned DIV_RESET = 63,
   parameter int unsigned DIV_MIN   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  apb_paddr,
   input  logic        apb_psel,
   input  logic        apb_penable,
   input  logic        apb_pwrite,
   input  logic [31:0] apb_pwdata,
   output logic [31:0] apb_prdata,
   output logic        apb_pready,
   output logic        apb_pslverr,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n,
   output logic        irq
);

   logic [2:0]       idx;
   logic             access;
   logic             stall;
   logic             wr_en;
   logic [31:0]      tx;
   logic [DIV_W-1:0] div;
   logic             cs;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;
   logic [31:0]      rx;
   logic [CNT_W-1:0] cnt_wr;
   logic [CNT_W-1:0] frame_len;
   logic             start;
   logic             clr_done;
   logic             unused_addr;

   assign idx         = apb_paddr[4:2];
   assign unused_addr = ^{apb_paddr[7:5], apb_paddr[1:0]};
   assign access      = apb_psel & apb_penable;
   assign stall       = access & apb_pwrite & busy &
                        ((idx == REG_DATA) | (idx == REG_CNT) | (idx == REG_DIV));
   assign apb_pready  = ~stall;
   assign apb_pslverr = 1'b0;
   assign wr_en       = access & apb_pwrite & ~stall;

   assign cnt_wr    = apb_pwdata[CNT_W-1:0];
   assign frame_len = (cnt_wr > CNT_W'(FRAME_MAX)) ? CNT_W'(FRAME_MAX) : cnt_wr;
   assign start     = wr_en & (idx == REG_CNT) & (cnt_wr != '0);
   assign clr_done  = wr_en & (idx == REG_STATUS) & apb_pwdata[STATUS_DONE];

   assign spi_cs_n = cs;
   assign irq      = done;

   // Register file: TX data, clamped divider, chip select
   always_ff @(posedge clk) begin
      if (reset) begin
         tx  <= '0;
         div <= DIV_W'(DIV_RESET);
         cs  <= 1'b1;
      end else if (wr_en) begin
         case (idx)
            REG_DATA: tx  <= apb_pwdata;
            REG_DIV:  div <= (apb_pwdata[DIV_W-1:0] < DIV_W'(DIV_MIN)) ?
                             DIV_W'(DIV_MIN) : apb_pwdata[DIV_W-1:0];
            REG_CS:   cs  <= apb_pwdata[0];
            default:  ;
         endcase
      end
   end

   // Combinational read mux
   always_comb begin
      apb_prdata = '0;
      if (apb_psel && !apb_pwrite) begin
         case (idx)
            REG_DATA:   apb_prdata = rx;
            REG_CNT:    apb_prdata = 32'(remaining);
            REG_STATUS: begin
               apb_prdata[STATUS_DONE] = done;
               apb_prdata[STATUS_BUSY] = busy;
            end
            REG_DIV:    apb_prdata = 32'(div);
            REG_CS:     apb_prdata = {31'b0, cs};
            default:    apb_prdata = '1;
         endcase
      end
   end

   spi_shift_core #(
      .DIV_W(DIV_W)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .frame_len (frame_len),
      .tx        (tx),
      .div       (div),
      .clr_done  (clr_done),
      .miso      (spi_miso),
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .rx        (rx),
      .sck       (spi_sck),
      .mosi      (spi_mosi)
   );

endmodule

// File: doc/apb_spi_master.md
Name: apb_spi_master

Overview:
- APB3 slave SPI shift engine (mode 0, MSB first, 1..32-bit frames) for the SD-card/SPI-flash port.
- Sits on the SoC's external APB2 bus, directly downstream of the CPU bus bridge.
- Drives SCK/MOSI/CS_n pads and samples MISO.
- Replaces software bit-banging; the CPU writes data, then the bit count, then polls busy or takes irq.

Parameters:
- DIV_W, 8, width of the clock-divider register.
- DIV_RESET, 63, reset divider value; SCK half-period = DIV+1 clk cycles (390 kHz at 50 MHz, SD init rate).
- DIV_MIN, 2, lowest accepted divider; smaller writes clamp to DIV_MIN (covers the MISO synchroniser latency).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- apb_paddr  in  8  byte address; only [4:2] decoded
- apb_psel  in  1  select
- apb_penable  in  1  access phase
- apb_pwrite  in  1  1 = write
- apb_pwdata  in  32  write data
- apb_prdata  out  32  read data
- apb_pready  out  1  ready; low stalls the access
- apb_pslverr  out  1  tied 0
- spi_sck  out  1  serial clock, idle low
- spi_mosi  out  1  serial out, idle high
- spi_miso  in  1  serial in, asynchronous
- spi_cs_n  out  1  chip select, software controlled
- irq  out  1  level; equals STATUS.done

Behaviour:
- Reset values: prdata 0, pready 1, sck 0, mosi 1, cs_n 1, irq 0, DIV=DIV_RESET, TX=0, RX=0, remaining=0, done=0, FSM=IDLE.
- Register map (offset):
  - 0x00 DATA: W loads TX[31:0]; R returns RX.
  - 0x04 CNT: W [5:0]=N starts a frame; N=0 is ignored; N>32 is treated as 32. R returns {26'b0, remaining}.
  - 0x08 STATUS: R {30'b0, done, busy}; W bit1=1 clears done.
  - 0x0C DIV: R/W [DIV_W-1:0], clamped to DIV_MIN.
  - 0x10 CS: R/W bit0 drives cs_n directly.
  - Other offsets: read 0xFFFFFFFF; writes ignored.
- APB access:
  - An access completes in the cycle where psel & penable & pready.
  - pready is 1 except during a write to DATA, CNT or DIV while busy. Such a write holds pready=0 until the FSM returns to IDLE, then completes on the next cycle.
  - Reads never stall.
  - prdata is combinational from the address and is valid during the access phase.
- MISO passes through a 2-flop synchroniser before it is sampled.
- FSM has three states: IDLE, LO, HI. A down-counter tc is loaded with DIV.
  - IDLE + CNT write (N): busy=1, done unchanged, remaining=N, RX shift register=0, mosi=TX[N-1], sck=0, tc=DIV, go to LO.
  - LO: tc decrements. At tc==0: rxsh={rxsh[30:0], miso_sync}, sck=1, tc=DIV, go to HI.
  - HI: tc decrements. At tc==0: sck=0, remaining-1.
    - If the new remaining==0: RX=rxsh (upper 32-N bits zero), done=1, busy=0, mosi=1, go to IDLE.
    - Else: mosi=TX[remaining-1] using the updated remaining, tc=DIV, go to LO.
- Frame latency: busy rises the cycle after the CNT write completes. done is set exactly N*2*(DIV+1) cycles after busy rises.
- CS is never touched by the FSM. A CS write while busy is accepted immediately and does not abort the frame.
- Simultaneous done-set and done-clear write: set wins.
- DIV changes take effect at the next tc reload.
- TX is not modified by shifting, so a frame can be repeated by writing CNT again.
- Reset mid-frame: all state returns to reset values in the next cycle; no partial RX update.

Decomposition:
- Shared package holds register offset constants (DATA/CNT/STATUS/DIV/CS), the STATUS bit indices, and the FSM state enum.
- One sub-module, spi_shift_core: FSM, divider, shift registers and pads.
- The top level keeps APB decode, the register file and the pready stall.

Test Plan:
- After reset, read STATUS, DIV, CS and 0x14 -> 0x0, 63, 0x1, 0xFFFFFFFF; sck=0, mosi=1, cs_n=1.
- DIV=2, DATA=0xA5, CNT=8, MISO loopback to MOSI -> 8 sck rising edges, each high 3 cycles; MOSI bits 1,0,1,0,0,1,0,1; done after 48 cycles; RX=0x000000A5; irq=1.
- DATA=0x80000001, CNT=32, miso tied 1 -> first MOSI bit 1, 30 zeros, last bit 1; RX=0xFFFFFFFF.
- During an active frame, write CNT=8 -> pready low until IDLE, then the access completes and a second frame starts; STATUS write 0x2 in the done-set cycle leaves done=1.
- Write DIV=0 -> reads back 2; CNT=0 -> busy stays 0; CNT=40 -> a 32-bit frame.
- Assert reset midway through a 16-bit frame -> next cycle sck=0, mosi=1, busy=0, done=0, RX=0, cs_n=1.
